// File: rtl/baud_pkg.sv
// Shared defaults and helpers for the baud rate generator.
package baud_pkg;

    localparam int unsigned DIV_RESET_DEF = 27;
    localparam int unsigned OVS_DEF       = 16;

    // Bits needed to hold values 0..v-1; never returns less than 1.
    function automatic int unsigned baud_clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if (((v - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/baud_rate_gen_if.sv
// Control and status bundle between a baud rate generator and its user.
interface baud_rate_gen_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned OVS_W = 4
);
    logic             en;
    logic             restart;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] count;
    logic [OVS_W-1:0] ovs_count;
    logic             sample_tick;
    logic             mid_tick;
    logic             bit_tick;

    modport master (
        output en, restart, div_in, div_load,
        input  div_cur, count, ovs_count, sample_tick, mid_tick, bit_tick
    );

    modport slave (
        input  en, restart, div_in, div_load,
        output div_cur, count, ovs_count, sample_tick, mid_tick, bit_tick
    );
endinterface

// File: rtl/prog_mod_counter.sv
// Modulo counter with a runtime modulus; a modulus of 0 behaves as 1.
module prog_mod_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W:0]   i_mod,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);
    logic [W-1:0] r_count;
    logic [W:0]   w_last;
    logic         w_at_last;

    // >= keeps a counter left above a shrunken modulus from running away.
    always_comb begin
        w_last    = (i_mod == '0) ? '0 : i_mod - (W+1)'(1);
        w_at_last = ({1'b0, r_count} >= w_last);
        o_wrap    = i_en & ~i_clr & ~rst & w_at_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_last ? '0 : r_count + W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/baud_rate_gen.sv
// Programmable prescaler plus oversample counter producing sample, mid-bit and end-of-bit ticks.
module baud_rate_gen
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned OVS       = OVS_DEF,
    parameter int unsigned DIV_RESET = DIV_RESET_DEF
) (
    input  logic           clk,
    input  logic           rst,
    baud_rate_gen_if.slave bus
);
    localparam int unsigned      OVS_W   = baud_clog2(OVS);
    localparam logic [OVS_W:0]   OVS_MOD = (OVS_W+1)'(OVS);
    localparam logic [OVS_W-1:0] OVS_MID = OVS_W'(OVS / 2 - 1);

    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend_vld;

    logic [CNT_W-1:0] w_count;
    logic [OVS_W-1:0] w_ovs_count;
    logic             w_sample_tick;
    logic             w_bit_tick;
    logic             w_apply;

    prog_mod_counter #(.W(CNT_W)) u_prescale (
        .clk     (clk),
        .rst     (rst),
        .i_en    (bus.en),
        .i_clr   (bus.restart),
        .i_mod   ({1'b0, r_div_cur}),
        .o_count (w_count),
        .o_wrap  (w_sample_tick)
    );

    prog_mod_counter #(.W(OVS_W)) u_ovs (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_sample_tick),
        .i_clr   (bus.restart),
        .i_mod   (OVS_MOD),
        .o_count (w_ovs_count),
        .o_wrap  (w_bit_tick)
    );

    // Divisor may only switch at a period boundary, while idle, or on realign.
    assign w_apply = w_sample_tick | ~bus.en | bus.restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cur  <= CNT_W'(DIV_RESET);
            r_div_pend <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_apply) begin
            if (bus.div_load) begin
                r_div_cur <= bus.div_in;
            end else if (r_pend_vld) begin
                r_div_cur <= r_div_pend;
            end
            r_pend_vld <= 1'b0;
        end else if (bus.div_load) begin
            r_div_pend <= bus.div_in;
            r_pend_vld <= 1'b1;
        end
    end

    assign bus.div_cur     = r_div_cur;
    assign bus.count       = w_count;
    assign bus.ovs_count   = w_ovs_count;
    assign bus.sample_tick = w_sample_tick;
    assign bus.bit_tick    = w_bit_tick;
    assign bus.mid_tick    = w_sample_tick & (w_ovs_count == OVS_MID);
endmodule

// File: tb/tb_baud_rate_gen.sv
// Scenario bench for baud_rate_gen with DIV_RESET=4, OVS=4; expected tick cycles are queued up front.
module tb_baud_rate_gen;
    import baud_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned OVS   = 4;
    localparam int unsigned OVS_W = baud_clog2(OVS);

    logic clk = 1'b0;
    logic rst = 1'b1;

    baud_rate_gen_if #(.CNT_W(CNT_W), .OVS_W(OVS_W)) bus ();

    baud_rate_gen #(.CNT_W(CNT_W), .OVS(OVS), .DIV_RESET(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sq[$];
    int mq[$];
    int bq[$];
    int exp_c;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 after reset release.
    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.restart = 1'b0;
        bus.div_load = 1'b0;
        bus.div_in = '0;
        sq.delete();
        mq.delete();
        bq.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.restart = 1'b0;
        bus.div_load = 1'b0;
        bus.div_in = '0;
        step();
        #1;
        n_tests++;
        if ({bus.sample_tick, bus.mid_tick, bus.bit_tick} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ticks: got %b, expected 000",
                     {bus.sample_tick, bus.mid_tick, bus.bit_tick});
        end
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.count !== 16'd0 || bus.ovs_count !== 2'd0 || bus.div_cur !== 16'd4) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d ovs=%0d div=%0d, expected 0 0 4",
                     bus.count, bus.ovs_count, bus.div_cur);
        end
    endtask

    task automatic test_ticks();
        do_reset();
        sq = '{3, 7, 11, 15};
        mq = '{7};
        bq = '{15};
        for (int c = 0; c <= 16; c++) begin
            #1;
            if (bus.sample_tick) begin
                n_tests++;
                exp_c = (sq.size() != 0) ? sq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL ticks_sample: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            if (bus.mid_tick) begin
                n_tests++;
                exp_c = (mq.size() != 0) ? mq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL ticks_mid: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            if (bus.bit_tick) begin
                n_tests++;
                exp_c = (bq.size() != 0) ? bq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL ticks_bit: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            step();
        end
        n_tests++;
        if (sq.size() + mq.size() + bq.size() != 0) begin
            n_fail++;
            $display("FAIL ticks_missing: got %0d ticks outstanding, expected 0",
                     sq.size() + mq.size() + bq.size());
        end
    endtask

    task automatic test_div_load();
        do_reset();
        sq = '{3, 7, 9, 11};
        for (int c = 0; c <= 12; c++) begin
            bus.div_load = (c == 5);
            bus.div_in = 16'd2;
            #1;
            if (c == 7 || c == 8) begin
                n_tests++;
                if (bus.div_cur !== ((c == 7) ? 16'd4 : 16'd2)) begin
                    n_fail++;
                    $display("FAIL load_div_cur: got %0d at cycle %0d, expected %0d",
                             bus.div_cur, c, (c == 7) ? 4 : 2);
                end
            end
            if (bus.sample_tick) begin
                n_tests++;
                exp_c = (sq.size() != 0) ? sq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL load_sample: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            step();
        end
        bus.div_load = 1'b0;
        n_tests++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL load_missing: got %0d ticks outstanding, expected 0", sq.size());
        end
    endtask

    task automatic test_restart();
        do_reset();
        sq = '{3, 7, 11, 18, 26};
        for (int c = 0; c <= 28; c++) begin
            bus.restart = (c == 14 || c == 22);
            #1;
            if (c == 14) begin
                n_tests++;
                if (bus.count !== 16'd2 || bus.ovs_count !== 2'd3) begin
                    n_fail++;
                    $display("FAIL restart_pre: got count=%0d ovs=%0d, expected 2 3",
                             bus.count, bus.ovs_count);
                end
            end
            if (c == 15) begin
                n_tests++;
                if (bus.count !== 16'd0 || bus.ovs_count !== 2'd0) begin
                    n_fail++;
                    $display("FAIL restart_clear: got count=%0d ovs=%0d, expected 0 0",
                             bus.count, bus.ovs_count);
                end
            end
            if (c == 22) begin
                n_tests++;
                if (bus.count !== 16'd3 || bus.sample_tick !== 1'b0) begin
                    n_fail++;
                    $display("FAIL restart_suppress: got count=%0d tick=%b, expected 3 0",
                             bus.count, bus.sample_tick);
                end
            end
            if (bus.sample_tick) begin
                n_tests++;
                exp_c = (sq.size() != 0) ? sq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL restart_sample: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            step();
        end
        bus.restart = 1'b0;
        n_tests++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL restart_missing: got %0d ticks outstanding, expected 0", sq.size());
        end
    endtask

    task automatic test_div_zero();
        do_reset();
        for (int k = 3; k <= 15; k++) sq.push_back(k);
        mq = '{4, 8, 12};
        bq = '{6, 10, 14};
        for (int c = 0; c <= 15; c++) begin
            bus.div_load = (c == 0);
            bus.div_in = 16'd0;
            #1;
            if (bus.sample_tick) begin
                n_tests++;
                exp_c = (sq.size() != 0) ? sq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL zero_sample: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            if (bus.mid_tick) begin
                n_tests++;
                exp_c = (mq.size() != 0) ? mq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL zero_mid: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            if (bus.bit_tick) begin
                n_tests++;
                exp_c = (bq.size() != 0) ? bq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL zero_bit: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            step();
        end
        bus.div_load = 1'b0;
        n_tests++;
        if (sq.size() + mq.size() + bq.size() != 0) begin
            n_fail++;
            $display("FAIL zero_missing: got %0d ticks outstanding, expected 0",
                     sq.size() + mq.size() + bq.size());
        end
        // N=1 with count=0 would tick every cycle unless reset gates it.
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.sample_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rst_gate: got sample_tick=%b, expected 0", bus.sample_tick);
        end
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.div_cur !== 16'd4) begin
            n_fail++;
            $display("FAIL zero_rst_div: got %0d, expected 4", bus.div_cur);
        end
    endtask

    task automatic test_en_low();
        do_reset();
        sq = '{15};
        for (int c = 0; c <= 16; c++) begin
            bus.div_load = (c == 1);
            bus.div_in = 16'd6;
            bus.en = !(c >= 2 && c <= 11);
            #1;
            if (c >= 2 && c <= 11) begin
                n_tests++;
                if (bus.count !== 16'd2 || bus.ovs_count !== 2'd0 ||
                    {bus.sample_tick, bus.mid_tick, bus.bit_tick} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL en_hold: cycle %0d got count=%0d ovs=%0d ticks=%b, expected 2 0 000",
                             c, bus.count, bus.ovs_count,
                             {bus.sample_tick, bus.mid_tick, bus.bit_tick});
                end
            end
            if (c == 2 || c == 3) begin
                n_tests++;
                if (bus.div_cur !== ((c == 2) ? 16'd4 : 16'd6)) begin
                    n_fail++;
                    $display("FAIL en_apply: got div=%0d at cycle %0d, expected %0d",
                             bus.div_cur, c, (c == 2) ? 4 : 6);
                end
            end
            if (bus.sample_tick) begin
                n_tests++;
                exp_c = (sq.size() != 0) ? sq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL en_sample: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            step();
        end
        bus.div_load = 1'b0;
        bus.en = 1'b1;
        n_tests++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL en_missing: got %0d ticks outstanding, expected 0", sq.size());
        end
    endtask

    task automatic test_reset_pending();
        int bad_div;
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            bus.div_load = (c == 1);
            bus.div_in = 16'd9;
            rst = (c >= 2);
            #1;
            if (c == 3) begin
                n_tests++;
                if ({bus.sample_tick, bus.mid_tick, bus.bit_tick} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rstpend_ticks: got %b, expected 000",
                             {bus.sample_tick, bus.mid_tick, bus.bit_tick});
                end
            end
            step();
        end
        rst = 1'b0;
        bus.div_load = 1'b0;
        sq = '{3, 7, 11};
        bad_div = 0;
        for (int c = 0; c <= 12; c++) begin
            #1;
            if (bus.div_cur !== 16'd4) bad_div++;
            if (bus.sample_tick) begin
                n_tests++;
                exp_c = (sq.size() != 0) ? sq.pop_front() : -1;
                if (c != exp_c) begin
                    n_fail++;
                    $display("FAIL rstpend_sample: got tick at %0d, expected %0d", c, exp_c);
                end
            end
            step();
        end
        n_tests++;
        if (bad_div != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL rstpend_div: got %0d cycles with div!=4 and %0d ticks outstanding, expected 0 0",
                     bad_div, sq.size());
        end
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_div_load();
        test_restart();
        test_div_zero();
        test_en_low();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/baud_rate_gen.md
BAUD_RATE_GEN -- requirements
Module: baud_rate_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of the divisor and prescale counter.
REQ-002 Parameter OVS, default 16, oversampling factor (sample ticks per bit); legal values are even and 2..256.
REQ-003 Parameter DIV_RESET, default 27, divisor loaded at reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  count enable; when low, counters hold and all ticks are 0.
REQ-007 restart  input  1  synchronous phase realign (RX start-edge alignment).
REQ-008 div_in  input  CNT_W  new divisor value.
REQ-009 div_load  input  1  one-cycle strobe that captures div_in.
REQ-010 div_cur  output  CNT_W  divisor currently in effect.
REQ-011 count  output  CNT_W  prescale counter value.
REQ-012 ovs_count  output  clog2(OVS)  sample-tick counter within the current bit.
REQ-013 sample_tick  output  1  one-cycle pulse, once per divisor period.
REQ-014 mid_tick  output  1  one-cycle pulse at mid-bit.
REQ-015 bit_tick  output  1  one-cycle pulse at end of bit.

Function
REQ-016 The effective divisor N SHALL be div_cur, with 0 treated as 1.
REQ-017 When en=1 and restart=0, count SHALL increment by 1 per cycle and wrap from N-1 to 0.
REQ-018 sample_tick SHALL be combinational: en and not restart and count==N-1.
REQ-019 With N=1, sample_tick SHALL be high every enabled cycle.
REQ-020 ovs_count SHALL increment on each sample_tick and wrap from OVS-1 to 0.
REQ-021 bit_tick SHALL equal sample_tick and ovs_count==OVS-1.
REQ-022 mid_tick SHALL equal sample_tick and ovs_count==OVS/2-1.
REQ-023 div_load SHALL capture div_in into a pending register and set a pending flag; a later div_load before application SHALL overwrite the pending value.
REQ-024 The pending value SHALL move to div_cur, and the flag SHALL clear, on the edge where sample_tick=1, or on any edge where en=0, or on restart.
REQ-025 When div_load coincides with an application edge, div_in SHALL be applied directly on that edge; the pending register is bypassed.
REQ-026 The divisor SHALL never change mid-period while en=1, so count never exceeds N-1.
REQ-027 restart=1 SHALL clear count and ovs_count on the next edge.
REQ-028 restart SHALL suppress all ticks in its cycle and take precedence over en.
REQ-029 Precedence SHALL be rst > restart > en.

Reset
REQ-030 rst=1 SHALL set count=0, ovs_count=0, div_cur=DIV_RESET, pending value=0 and pending flag=0.
REQ-031 Ticks SHALL be 0 while rst=1.
REQ-032 Reset asserted mid-period SHALL discard any pending divisor.

Structure
REQ-033 Package baud_pkg SHALL hold the DIV_RESET and OVS defaults and a clog2 helper function.
REQ-034 The prescaler and the oversample counter SHALL each be an instance of one sub-module, prog_mod_counter, which has: runtime modulus, enable, clear, count output and wrap output.
REQ-035 Divisor shadowing logic SHALL reside in the top level.

Verification
REQ-036 Reset release with en=1, DIV_RESET=4, OVS=4 -> sample_tick in cycles 3, 7, 11, 15; mid_tick in cycle 7; bit_tick in cycle 15.
REQ-037 div_load with div_in=2 at cycle 5 while N=4 -> div_cur changes at the cycle-7 edge; next sample_ticks at cycles 9 and 11.
REQ-038 restart pulse at count=2, ovs_count=3 -> both counters read 0 on the next cycle, no tick in the restart cycle, next sample_tick N cycles later.
REQ-039 div_in=0 loaded, en=1 -> sample_tick every cycle; bit_tick every OVS cycles.
REQ-040 en low for 10 cycles mid-period -> count and ovs_count hold, ticks 0, pending divisor applied on the first en=0 edge.
REQ-041 rst asserted with a divisor load pending -> div_cur=DIV_RESET afterwards and the pending value is never applied.
